// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART TX feeder slice.
//   - default widths/depth/timeout used by the interface and modules
//   - feeder FSM state encoding
package uart_tx_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_ACK_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_ACK  = 2'b11,
    ST_WAIT_DONE = 2'b10
  } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// System-side and TX-controller-side signals of the feeder.
//   master : system / TX controller side (drives writes, clear and busy)
//   slave  : the feeder itself
interface uart_tx_feeder_if
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  clr_err;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  tx_data_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LVL_W-1:0]      fill_level;
  logic                  overflow;
  logic                  ack_err;

  modport master (
    output wr_en, wr_data, clr_err, tx_busy,
    input  tx_p_data, tx_data_valid, fifo_full, fifo_empty, fill_level, overflow, ack_err
  );

  modport slave (
    input  wr_en, wr_data, clr_err, tx_busy,
    output tx_p_data, tx_data_valid, fifo_full, fifo_empty, fill_level, overflow, ack_err
  );

endinterface

// File: rtl/uart_tx_feeder_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the TX launcher.
//   clk_i, rst_i   : clock, async active-high reset
//   push_i/_data_i : write request and data
//   pop_i          : consume head (ignored when empty)
//   head_o         : current head word
//   full_o/empty_o : occupancy flags, count_o : entry count
//   drop_o         : a push was refused this cycle
module uart_sync_fifo
  import uart_tx_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [LVL_W-1:0]      count_o,
  output logic                  drop_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      count_q;
  logic                  do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != LVL_W'(FIFO_DEPTH)) || do_pop);
  assign drop_o  = push_i && !do_push;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == LVL_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues system bytes and launches them one at a time into the UART TX
// controller, pacing on its busy flag and retrying unacknowledged launches.
//   clk_i : block clock
//   rst_i : async active-high reset
//   bus   : system writes, error clear, TX handshake and status (slave side)
//
// state        | meaning
// ST_IDLE      | wait for data and TX idle, then pop head and launch
// ST_ISSUE     | one-cycle launch pulse on tx_data_valid
// ST_WAIT_ACK  | wait for tx_busy to rise, relaunch on timeout
// ST_WAIT_DONE | wait for tx_busy to fall
module uart_tx_feeder
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input logic           clk_i,
  input logic           rst_i,
  uart_tx_feeder_if.slave bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(ACK_TIMEOUT - 1);

  feeder_state_e         state_q;
  logic [DATA_WIDTH-1:0] tx_p_data_q;
  logic                  tx_data_valid_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ack_err_q, ack_err_d;
  logic                  overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full, fifo_empty, fifo_drop;
  logic [LVL_W-1:0]      fifo_count;
  logic                  launch, ack_expire;

  assign launch     = (state_q == ST_IDLE) && !fifo_empty && !bus.tx_busy;
  assign ack_expire = (state_q == ST_WAIT_ACK) && !bus.tx_busy && (cnt_q == CNT_TERM);

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (bus.wr_en),
    .push_data_i (bus.wr_data),
    .pop_i       (launch),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .drop_o      (fifo_drop)
  );

  // A new error event in the same cycle as a clear keeps the flag set.
  assign overflow_d = fifo_drop  || (overflow_q && !bus.clr_err);
  assign ack_err_d  = ack_expire || (ack_err_q  && !bus.clr_err);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      tx_p_data_q     <= '0;
      tx_data_valid_q <= 1'b0;
      cnt_q           <= '0;
      ack_err_q       <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      ack_err_q  <= ack_err_d;
      overflow_q <= overflow_d;
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            tx_p_data_q     <= fifo_head;
            tx_data_valid_q <= 1'b1;
            state_q         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tx_data_valid_q <= 1'b0;
          cnt_q           <= '0;
          state_q         <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (bus.tx_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == CNT_TERM) begin
            // Relaunch the held byte; the FIFO is not popped again.
            tx_data_valid_q <= 1'b1;
            state_q         <= ST_ISSUE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_p_data     = tx_p_data_q;
  assign bus.tx_data_valid = tx_data_valid_q;
  assign bus.fifo_full     = fifo_full;
  assign bus.fifo_empty    = fifo_empty;
  assign bus.fill_level    = fifo_count;
  assign bus.overflow      = overflow_q;
  assign bus.ack_err       = ack_err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple TX controller model:
// busy rises two cycles after each launch and stays high for ten cycles.
module tb_uart_tx_feeder;
  import uart_tx_pkg::*;

  localparam int DW = 8;
  localparam int FD = 8;
  localparam int AT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  uart_tx_feeder #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (FD),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // TX controller model and launch log
  logic       model_en;
  logic       man_busy;
  logic       model_busy = 1'b0;
  int         dly        = 0;
  int         bcnt       = 0;
  int         pulse_cnt  = 0;
  int         busy_viol  = 0;
  logic [7:0] tx_log [64];

  assign bus.tx_busy = model_en ? model_busy : man_busy;

  always @(negedge clk) begin
    if (rst) begin
      model_busy <= 1'b0;
      dly        <= 0;
      bcnt       <= 0;
    end else if (bus.tx_data_valid) begin
      if (pulse_cnt < 64) tx_log[pulse_cnt] <= bus.tx_p_data;
      pulse_cnt <= pulse_cnt + 1;
      if (bus.tx_busy) busy_viol <= busy_viol + 1;
      dly <= 2;
    end else if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        model_busy <= 1'b1;
        bcnt       <= 10;
      end
    end else if (model_busy) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) model_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one write for the next rising edge; returns on the following negedge.
  task automatic write(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  int p0;

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clr_err = 1'b0;
    model_en    = 1'b1;
    man_busy    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.tx_data_valid), 0);
    check("rst_pdata", 32'(bus.tx_p_data), 0);
    check("rst_fill", 32'(bus.fill_level), 0);
    check("rst_empty", 32'(bus.fifo_empty), 1);
    check("rst_full", 32'(bus.fifo_full), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_ackerr", 32'(bus.ack_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte, launch two cycles after the write
    p0 = pulse_cnt;
    write(8'hA5);
    check("t1_valid_n1", 32'(bus.tx_data_valid), 0);
    check("t1_fill_n1", 32'(bus.fill_level), 1);
    @(negedge clk);
    check("t1_valid_n2", 32'(bus.tx_data_valid), 1);
    check("t1_pdata", 32'(bus.tx_p_data), 32'hA5);
    check("t1_fill_n2", 32'(bus.fill_level), 0);
    @(negedge clk);
    check("t1_valid_off", 32'(bus.tx_data_valid), 0);
    check("t1_pdata_hold", 32'(bus.tx_p_data), 32'hA5);
    repeat (20) @(negedge clk);
    check("t1_pulses", 32'(pulse_cnt - p0), 1);
    check("t1_fill_end", 32'(bus.fill_level), 0);

    // 2: burst of 8 with TX held busy, then drain in order (pointers wrap)
    model_en = 1'b0;
    man_busy = 1'b1;
    for (int i = 1; i <= 8; i++) write(8'(i));
    check("t2_full", 32'(bus.fifo_full), 1);
    check("t2_fill", 32'(bus.fill_level), 8);
    p0       = pulse_cnt;
    man_busy = 1'b0;
    model_en = 1'b1;
    repeat (200) @(negedge clk);
    check("t2_pulses", 32'(pulse_cnt - p0), 8);
    for (int i = 0; i < 8; i++) check("t2_order", 32'(tx_log[p0 + i]), 32'(i + 1));
    check("t2_busy_viol", 32'(busy_viol), 0);
    check("t2_empty", 32'(bus.fifo_empty), 1);

    // 3: overflow, set-wins against clear, then clear
    model_en = 1'b0;
    man_busy = 1'b1;
    for (int i = 0; i < 8; i++) write(8'(8'h11 + i));
    check("t3_full", 32'(bus.fifo_full), 1);
    write(8'hFF);
    check("t3_ovf_set", 32'(bus.overflow), 1);
    check("t3_fill", 32'(bus.fill_level), 8);
    bus.clr_err = 1'b1;
    write(8'h22);
    bus.clr_err = 1'b0;
    check("t3_set_wins", 32'(bus.overflow), 1);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    check("t3_ovf_clr", 32'(bus.overflow), 0);

    // 5: full FIFO, pop and write in the same IDLE cycle
    p0       = pulse_cnt;
    man_busy = 1'b0;
    model_en = 1'b1;
    write(8'h77);
    check("t5_fill", 32'(bus.fill_level), 8);
    check("t5_ovf", 32'(bus.overflow), 0);
    check("t5_valid", 32'(bus.tx_data_valid), 1);
    check("t5_pdata", 32'(bus.tx_p_data), 32'h11);
    repeat (200) @(negedge clk);
    check("t5_pulses", 32'(pulse_cnt - p0), 9);
    for (int i = 0; i < 8; i++) check("t3_t5_order", 32'(tx_log[p0 + i]), 32'(8'h11 + i));
    check("t5_last", 32'(tx_log[p0 + 8]), 32'h77);
    check("t5_empty", 32'(bus.fifo_empty), 1);
    check("t5_busy_viol", 32'(busy_viol), 0);

    // 4: no acknowledge, retry after the timeout
    model_en = 1'b0;
    man_busy = 1'b0;
    write(8'h3C);
    write(8'h5A);
    check("t4_valid1", 32'(bus.tx_data_valid), 1);
    check("t4_pdata1", 32'(bus.tx_p_data), 32'h3C);
    check("t4_fill1", 32'(bus.fill_level), 1);
    repeat (16) @(negedge clk);
    check("t4_valid_pre", 32'(bus.tx_data_valid), 0);
    check("t4_ackerr_pre", 32'(bus.ack_err), 0);
    @(negedge clk);
    check("t4_valid2", 32'(bus.tx_data_valid), 1);
    check("t4_ackerr", 32'(bus.ack_err), 1);
    check("t4_pdata2", 32'(bus.tx_p_data), 32'h3C);
    check("t4_fill2", 32'(bus.fill_level), 1);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    check("t4_ackerr_clr", 32'(bus.ack_err), 0);

    // 6: reset while waiting for TX to finish with 3 entries queued
    man_busy = 1'b1;
    @(negedge clk);
    write(8'h61);
    write(8'h62);
    check("t6_fill_pre", 32'(bus.fill_level), 3);
    rst = 1'b1;
    #1;
    check("t6_valid", 32'(bus.tx_data_valid), 0);
    check("t6_pdata", 32'(bus.tx_p_data), 0);
    check("t6_fill", 32'(bus.fill_level), 0);
    check("t6_empty", 32'(bus.fifo_empty), 1);
    man_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    p0  = pulse_cnt;
    repeat (20) @(negedge clk);
    check("t6_no_pulse", 32'(pulse_cnt - p0), 0);
    check("t6_empty_end", 32'(bus.fifo_empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
